// File: rtl/eth_pkg.sv
// Shared framing constants and types for the PC Ethernet link.
// The TX framer and the RX decoder both use this package.
package eth_pkg;

    localparam logic [47:0] MAC_PC           = 48'h0019E075BFFD;
    localparam logic [47:0] MAC_FPGA         = 48'h0019E0000001;
    localparam logic [15:0] CMD_DATA         = 16'h0300;
    localparam logic [15:0] CMD_ACK          = 16'h0100;
    localparam logic [15:0] CMD_END          = 16'h0200;
    localparam logic [11:0] LENGTH           = 12'd1040;
    localparam logic [11:0] SHORT_LENGTH     = 12'h034;
    localparam int          HDR_WORDS        = 4;
    localparam int          STATUS_PAY_WORDS = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        DONE = 2'd3
    } tx_state_e;

    typedef enum logic {
        KIND_DATA   = 1'b0,
        KIND_STATUS = 1'b1
    } frame_kind_e;

    // Header words are big-endian: dst MAC, src MAC, then {len, cmd}.
    function automatic logic [31:0] hdr_word(input logic [1:0]  idx,
                                             input logic [11:0] len,
                                             input logic [15:0] cmd);
        logic [31:0] w;
        case (idx)
            2'd0:    w = MAC_PC[47:16];
            2'd1:    w = {MAC_PC[15:0], MAC_FPGA[47:32]};
            2'd2:    w = MAC_FPGA[31:0];
            default: w = {4'h0, len, cmd};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/eth_tx_framer_skid_buf.sv
// Two-entry FIFO that absorbs row-buffer read latency so payload words
// can be held stable under tx_ready backpressure.
module tx_skid_buf #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // The producer never pushes into a full buffer, and pop only happens
    // while valid_o is high, so no overflow/underflow guard is needed here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/eth_tx_framer.sv
// Builds DATA (one image row) and STATUS frames as 32-bit words for the MAC TX FIFO.
// A word transfers on a cycle where tx_valid && tx_ready; tx_* hold while stalled.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int WIDTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cmd,
    input  logic [31:0] status_word,
    output logic [8:0]  rd_addr,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        busy,
    output logic        cmd_err,
    output logic [1:0]  dbg_state
);

    localparam logic [8:0]  LAST_ADDR  = 9'(WIDTH / 4 - 1);
    localparam logic [11:0] DATA_LEN   = 12'(WIDTH + 16);
    localparam logic [3:0]  LAST_STAT  = 4'(STATUS_PAY_WORDS - 1);

    tx_state_e   state_q, state_d;
    frame_kind_e kind_q;
    logic [15:0] cmd_q;
    logic [31:0] status_q;
    logic [1:0]  hdr_idx_q;
    logic [3:0]  pay_idx_q;
    logic [8:0]  rd_addr_q;
    logic        rd_done_q;
    logic        rd_pend_q;
    logic        rd_pend_last_q;
    logic        cmd_err_q;

    logic        cmd_is_data;
    logic        cmd_is_status;
    logic        accept;
    logic        hs;
    logic        skid_pop;
    logic        skid_valid;
    logic [33:0] skid_data;
    logic [1:0]  skid_count;
    logic [2:0]  occ;
    logic        fetch_window;
    logic [11:0] frame_len;

    assign cmd_is_data   = (cmd == CMD_DATA);
    assign cmd_is_status = (cmd == CMD_ACK) || (cmd == CMD_END);
    assign accept        = (state_q == IDLE) && start && (cmd_is_data || cmd_is_status);
    assign hs            = tx_valid && tx_ready;
    assign frame_len     = (kind_q == KIND_DATA) ? DATA_LEN : SHORT_LENGTH;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = HDR;
            HDR:     if (hs && hdr_idx_q == 2'd3) state_d = PAY;
            PAY:     if (hs && tx_eof) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 32'd0;
        tx_sof   = 1'b0;
        tx_eof   = 1'b0;
        skid_pop = 1'b0;
        case (state_q)
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_word(hdr_idx_q, frame_len, cmd_q);
                tx_sof   = (hdr_idx_q == 2'd0);
            end
            PAY: begin
                if (kind_q == KIND_DATA) begin
                    tx_valid = skid_valid;
                    tx_data  = skid_data[31:0];
                    tx_sof   = skid_data[32];
                    tx_eof   = skid_data[33];
                    skid_pop = skid_valid && tx_ready;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = (pay_idx_q == 4'd0) ? status_q : 32'd0;
                    tx_eof   = (pay_idx_q == LAST_STAT);
                end
            end
            default: ;
        endcase
    end

    // Reads start during W2 so the first payload word is buffered by the
    // HDR->PAY boundary; issue only when the skid buffer can take the result.
    assign fetch_window = (kind_q == KIND_DATA) &&
                          (((state_q == HDR) && hdr_idx_q[1]) || (state_q == PAY));
    assign occ          = {1'b0, skid_count} + {2'b00, rd_pend_q} - {2'b00, skid_pop};
    assign rd_en        = fetch_window && !rd_done_q && (occ < 3'd2);
    assign rd_addr      = rd_addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kind_q         <= KIND_DATA;
            cmd_q          <= 16'd0;
            status_q       <= 32'd0;
            hdr_idx_q      <= 2'd0;
            pay_idx_q      <= 4'd0;
            rd_addr_q      <= 9'd0;
            rd_done_q      <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            cmd_err_q <= (state_q == IDLE) && start && !(cmd_is_data || cmd_is_status);
            if (accept) begin
                kind_q    <= cmd_is_data ? KIND_DATA : KIND_STATUS;
                cmd_q     <= cmd;
                status_q  <= status_word;
                hdr_idx_q <= 2'd0;
                pay_idx_q <= 4'd0;
                rd_addr_q <= 9'd0;
                rd_done_q <= 1'b0;
            end
            if (state_q == HDR && hs) begin
                hdr_idx_q <= hdr_idx_q + 2'd1;
            end
            if (state_q == PAY && hs && kind_q == KIND_STATUS) begin
                pay_idx_q <= pay_idx_q + 4'd1;
            end
            if (rd_en) begin
                if (rd_addr_q == LAST_ADDR) begin
                    rd_done_q <= 1'b1;
                end else begin
                    rd_addr_q <= rd_addr_q + 9'd1;
                end
            end
            rd_pend_q      <= rd_en;
            rd_pend_last_q <= rd_en && (rd_addr_q == LAST_ADDR);
        end
    end

    tx_skid_buf #(.W(34)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_pend_q),
        .data_i  ({rd_pend_last_q, 1'b0, rd_data}),
        .pop_i   (skid_pop),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .count_o (skid_count)
    );

    assign busy      = (state_q == HDR) || (state_q == PAY);
    assign cmd_err   = cmd_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: table of frame requests plus reset/abort sequences.
module tb_eth_tx_framer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] cmd;
  logic [31:0] status_word;
  logic [8:0]  rd_addr;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sof;
  logic        tx_eof;
  logic        busy;
  logic        cmd_err;
  logic [1:0]  dbg_state;

  int tests;
  int fails;
  logic [33:0] exp_q[$];

  eth_tx_framer #(.WIDTH(1024)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cmd         (cmd),
    .status_word (status_word),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_sof      (tx_sof),
    .tx_eof      (tx_eof),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset / row-buffer model (buffer[i] = i, one-cycle read latency)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= {23'd0, rd_addr};
  end

  typedef struct {
    logic [15:0] cmd;
    logic [31:0] sw;
    int          rmode;
    int          exp_words;
    int          exp_rd;
    int          exp_err;
    int          again;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 25) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_exp(input logic [15:0] c, input logic [31:0] sw);
    logic [11:0] len;
    exp_q.delete();
    len = (c == 16'h0300) ? 12'd1040 : 12'h034;
    exp_q.push_back({2'b01, 32'h0019E075});
    exp_q.push_back({2'b00, 32'hBFFD0019});
    exp_q.push_back({2'b00, 32'hE0000001});
    exp_q.push_back({2'b00, 4'h0, len, c});
    if (c == 16'h0300) begin
      for (int i = 0; i < 256; i++) exp_q.push_back({(i == 255), 1'b0, 32'(i)});
    end else begin
      exp_q.push_back({2'b00, sw});
      for (int i = 1; i < 9; i++) exp_q.push_back({(i == 8), 1'b0, 32'd0});
    end
  endtask

  task automatic send_frame(input vec_t v);
    int cyc, got, rd_cnt, err_cnt, gaps, any_valid, any_busy, idle_valid, limit;
    logic done, stalled;
    logic [33:0] held, exp;
    if (v.exp_words > 0) build_exp(v.cmd, v.sw);
    else exp_q.delete();
    limit = (v.exp_words > 0) ? 4000 : 20;
    @(negedge clk);
    start = 1'b1; cmd = v.cmd; status_word = v.sw;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; got = 0; rd_cnt = 0; err_cnt = 0; gaps = 0; any_valid = 0; any_busy = 0;
    done = 1'b0; stalled = 1'b0; held = '0;
    while (!done && cyc < limit) begin
      tx_ready = (v.rmode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (cyc == v.again) start = 1'b1;
      #1;
      if (cyc == 0 && v.exp_words > 0 && v.rmode == 0)
        check("first_word_latency", {busy, tx_valid, tx_sof}, 3'b111);
      if (stalled) check("stall_hold", {tx_valid, tx_eof, tx_sof, tx_data}, {1'b1, held});
      if (cmd_err) err_cnt++;
      if (rd_en) rd_cnt++;
      if (tx_valid) any_valid++;
      if (busy) any_busy++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", {tx_eof, tx_sof, tx_data}, 34'h3_FFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          check("word", {tx_eof, tx_sof, tx_data}, exp);
        end
        got++;
        if (tx_eof) done = 1'b1;
      end else if (got > 0 && v.rmode == 0) begin
        gaps++;
      end
      stalled = tx_valid && !tx_ready;
      held = {tx_eof, tx_sof, tx_data};
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("cmd_err_pulses", err_cnt, v.exp_err);
    if (v.exp_words > 0) begin
      check("frame_done", done, 1'b1);
      check("word_count", got, v.exp_words);
      check("rd_en_pulses", rd_cnt, v.exp_rd);
      check("exp_q_empty", exp_q.size(), 0);
      if (v.rmode == 0) check("no_bubbles", gaps, 0);
      #1;
      check("busy_fall", busy, 1'b0);
    end else begin
      check("no_valid_on_err", any_valid, 0);
      check("no_busy_on_err", any_busy, 0);
    end
    idle_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (tx_valid || busy) idle_valid++;
    end
    check("no_second_frame", idle_valid, 0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {tx_valid, tx_sof, tx_eof, busy, rd_en, cmd_err, rd_addr, tx_data}, 64'd0);
  endtask

  initial begin
    int cyc, got;
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; cmd = 16'd0; status_word = 32'd0; tx_ready = 1'b1;
    vecs[0] = '{16'h0300, 32'h0000_0000, 0, 260, 256, 0, -1};
    vecs[1] = '{16'h0100, 32'hDEAD_BEEF, 0, 13, 0, 0, -1};
    vecs[2] = '{16'h0300, 32'h0000_0000, 1, 260, 256, 0, -1};
    vecs[3] = '{16'h0400, 32'h0000_0000, 0, 0, 0, 1, -1};
    vecs[4] = '{16'h0200, 32'h1234_5678, 1, 13, 0, 0, -1};
    vecs[5] = '{16'h0300, 32'h0000_0000, 0, 260, 256, 0, 95};

    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) send_frame(vecs[k]);

    // abort a DATA frame with a one-cycle reset at payload word 100
    @(negedge clk);
    start = 1'b1; cmd = 16'h0300; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; got = 0;
    while (got < 104 && cyc < 1000) begin
      #1;
      if (tx_valid && tx_ready) got++;
      @(negedge clk);
      cyc++;
    end
    check("abort_reached", got, 104);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("reset_mid_frame");
    repeat (2) @(negedge clk);
    send_frame(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Transmit-side frame builder for the PC Ethernet link; produces the frames the PC-facing receive decoder expects to see in the opposite direction.
- Emits 32-bit words toward the MAC TX interface.
- Two frame kinds:
  - DATA frames carry one image row of WIDTH bytes from a row buffer.
  - Short STATUS frames answer command/ack traffic.
- Sits between the row-buffer/readout controller and the MAC TX FIFO.

Parameters:
- WIDTH, 1024, image row length in bytes; multiple of 4.
- LENGTH, WIDTH+16 (1040), DATA frame byte count excluding FCS.
- SHORT_LENGTH, 12'h034 (52), STATUS frame byte count excluding FCS.
- MAC_PC, 48'h0019E075BFFD, destination MAC.
- MAC_FPGA, 48'h0019E0000001, source MAC.
- CMD_DATA, 16'h0300, command code for DATA frames.
- CMD_ACK, 16'h0100, STATUS command code.
- CMD_END, 16'h0200, STATUS command code.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to send a frame
- cmd  in  16  command code, sampled on accepted start
- status_word  in  32  STATUS payload word 0, sampled on accepted start
- rd_addr  out  9  row buffer word address
- rd_en  out  1  row buffer read strobe
- rd_data  in  32  row buffer data, valid 1 cycle after rd_en
- tx_data  out  32  frame word
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts word when tx_valid&&tx_ready
- tx_sof  out  1  first word of frame, qualified by tx_valid
- tx_eof  out  1  last word of frame, qualified by tx_valid
- busy  out  1  frame in progress
- cmd_err  out  1  one-cycle pulse: start with unsupported cmd

Behaviour:
- Reset (rst_n low at clk edge):
  - All outputs go to 0 on the next edge; FSM goes to IDLE.
  - This applies mid-frame: the frame is abandoned, no eof is emitted, and the skid register is cleared.
- Start acceptance:
  - start is accepted only in IDLE.
  - While busy, start is ignored with no error.
  - cmd is decoded on the accepted cycle:
    - CMD_DATA → DATA frame.
    - CMD_ACK or CMD_END → STATUS frame.
    - Any other value → cmd_err=1 for one cycle, remain IDLE.
- busy:
  - Rises the cycle after an accepted start.
  - Falls the cycle after the eof handshake.
- Frame word layout (big-endian bytes, 4 header words = 16 bytes):
  - W0 = MAC_PC[47:16]
  - W1 = {MAC_PC[15:0], MAC_FPGA[47:32]}
  - W2 = MAC_FPGA[31:0]
  - W3 = {4'h0, frame_len[11:0], cmd}, where frame_len = LENGTH or SHORT_LENGTH.
- Payload:
  - DATA: WIDTH/4 words (256), taken from rd_data at addresses 0..WIDTH/4-1 in order. Total 260 words.
  - STATUS: 9 words; P0 = status_word, P1..P8 = 0. Total 13 words. No buffer reads.
- FSM states and transitions:
  - IDLE → HDR on valid start.
  - HDR (word index 0..3) → PAY after the W3 handshake.
  - PAY → DONE after the last-word handshake.
  - DONE → IDLE in one cycle; busy=0 in IDLE.
- Output framing:
  - tx_sof=1 with W0 only; tx_eof=1 with the last payload word only.
- Handshake:
  - tx_data, tx_sof and tx_eof hold stable while tx_valid && !tx_ready.
  - tx_valid never drops mid-frame except during the first-fetch latency.
- Throughput:
  - With tx_ready held high: first W0 is valid 1 cycle after start.
  - No bubbles anywhere, including the HDR→PAY boundary; prefetch rd_addr 0 during W2/W3.
  - A DATA frame occupies exactly 260 consecutive valid cycles.
- Backpressure:
  - rd_en is issued only when the 2-entry skid buffer can absorb the result.
  - No read is lost or duplicated under any tx_ready pattern.
- Address counter:
  - 9-bit, counts 0..WIDTH/4-1, then stops with no wrap.
  - rd_en=0 after the last read.

Decomposition:
- Package eth_pkg:
  - Constants: MAC_PC, MAC_FPGA, CMD_DATA, CMD_ACK, CMD_END, LENGTH, SHORT_LENGTH, HDR_WORDS=4, STATUS_PAY_WORDS=9.
  - FSM state enum {IDLE, HDR, PAY, DONE}.
  - The receive decoder also uses these constants.
- Sub-module: tx_skid_buf (2-entry 32+2-bit skid register) decoupling rd_data latency from tx_ready.

Test Plan:
1. DATA frame, tx_ready=1, buffer[i]=i:
   - 260 consecutive valid words.
   - W0=32'h0019E075, W3=32'h04100300, payload 0..255.
   - sof on W0, eof on word 259.
2. STATUS frame, cmd=16'h0100, status_word=32'hDEADBEEF:
   - 13 words, W3=32'h00340100, P0=32'hDEADBEEF, P1..P8=0.
   - rd_en never asserted.
3. DATA frame with random tx_ready (50%):
   - Payload sequence identical to scenario 1, held stable during stalls.
   - Exactly 256 rd_en pulses.
4. cmd=16'h0400 start:
   - cmd_err=1 for 1 cycle, tx_valid stays 0, busy stays 0.
   - A subsequent cmd=16'h0200 frame then sends normally.
5. start pulses at cycles 5 and 100 during a DATA frame:
   - Second pulse ignored; only one frame emitted; cmd_err=0.
6. rst_n=0 for one cycle at payload word 100:
   - Next cycle all outputs 0, busy=0.
   - A new start produces a full 260-word frame with sof on W0.
